// File: rtl/mips_arb_pkg.sv
// Shared constants for the MIPS datapath adder arbiter: default widths,
// requester limits and well-known requester IDs.
package mips_arb_pkg;

    localparam int unsigned DEFAULT_LEN = 11;
    localparam int unsigned MAX_NUM_REQ = 4;

    typedef enum logic [1:0] {
        REQ_PC     = 2'd0,
        REQ_BRANCH = 2'd1,
        REQ_DEBUG  = 2'd2
    } req_id_e;

endpackage

// File: rtl/adder_arbiter_rr_rr_picker.sv
// Combinational round-robin search: first requester at or after ptr,
// wrapping modulo NUM_REQ. Out-of-range pointers behave as 0.
module rr_picker #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned ID_LENGTH = 1
) (
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [ID_LENGTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [ID_LENGTH-1:0] idx
);

    int unsigned base;
    int unsigned off;
    int unsigned best_off;
    logic        found;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        off      = 0;
        best_off = NUM_REQ;
        base     = (32'(ptr) >= NUM_REQ) ? 0 : 32'(ptr);
        // Smallest upward distance from the pointer wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            off = (k >= base) ? (k - base) : (k + NUM_REQ - base);
            if (en && req[k] && off < best_off) begin
                best_off = off;
                idx      = ID_LENGTH'(k);
                found    = 1'b1;
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            grant[k] = found && (ID_LENGTH'(k) == idx);
        end
    end

endmodule

// File: rtl/adder_signado.sv
// Unsigned base plus two's-complement offset, result truncated to LEN bits.
module adder_signado #(
    parameter int unsigned INPUT_OUTPUT_LENGTH = 11
) (
    input  logic [INPUT_OUTPUT_LENGTH-1:0] i_data_A,
    input  logic [INPUT_OUTPUT_LENGTH-1:0] i_data_B,
    output logic [INPUT_OUTPUT_LENGTH-1:0] o_result
);

    assign o_result = i_data_A + i_data_B;

endmodule

// File: rtl/adder_arbiter_rr.sv
// Round-robin shared signed-offset adder with registered, ID-tagged result.
// Optional registered overflow flag when ADDER_ARB_OVF_EN is defined.
module adder_arbiter_rr
    import mips_arb_pkg::*;
#(
    parameter int unsigned INPUT_OUTPUT_LENGTH = DEFAULT_LEN,
    parameter int unsigned NUM_REQ             = 2,
    parameter int unsigned ID_LENGTH           = 1
) (
    input  logic                                   i_clock,
    input  logic                                   i_reset,
    input  logic [NUM_REQ-1:0]                     i_req,
    input  logic [NUM_REQ*INPUT_OUTPUT_LENGTH-1:0] i_data_A,
    input  logic [NUM_REQ*INPUT_OUTPUT_LENGTH-1:0] i_data_B,
    output logic [NUM_REQ-1:0]                     o_grant,
    output logic                                   o_valid,
    output logic [INPUT_OUTPUT_LENGTH-1:0]         o_result,
    output logic [ID_LENGTH-1:0]                   o_req_id,
`ifdef ADDER_ARB_OVF_EN
    output logic                                   o_overflow,
`endif
    input  logic                                   i_ready
);

    localparam int unsigned LEN = INPUT_OUTPUT_LENGTH;
    localparam logic [ID_LENGTH-1:0] LAST_ID = ID_LENGTH'(NUM_REQ - 1);

    logic                 slot_free;
    logic                 pick_en;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_LENGTH-1:0] win_idx;
    logic [ID_LENGTH-1:0] ptr;
    logic [LEN-1:0]       a_sel;
    logic [LEN-1:0]       b_sel;
    logic [LEN-1:0]       sum;

    assign slot_free = !o_valid || i_ready;
    assign pick_en   = slot_free && !i_reset;
    assign o_grant   = grant;

    rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .ID_LENGTH (ID_LENGTH)
    ) u_picker (
        .en    (pick_en),
        .req   (i_req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                a_sel = i_data_A[k*LEN +: LEN];
                b_sel = i_data_B[k*LEN +: LEN];
            end
        end
    end

    adder_signado #(
        .INPUT_OUTPUT_LENGTH (LEN)
    ) u_adder (
        .i_data_A (a_sel),
        .i_data_B (b_sel),
        .o_result (sum)
    );

`ifdef ADDER_ARB_OVF_EN
    // Two guard bits hold the exact sum; either set means outside [0, 2^LEN-1].
    logic [LEN+1:0] wide_sum;
    logic           ovf_next;
    assign wide_sum = {2'b00, a_sel} + {{2{b_sel[LEN-1]}}, b_sel};
    assign ovf_next = wide_sum[LEN+1] | wide_sum[LEN];
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_req_id   <= '0;
            ptr        <= '0;
`ifdef ADDER_ARB_OVF_EN
            o_overflow <= 1'b0;
`endif
        end else if (|grant) begin
            o_valid    <= 1'b1;
            o_result   <= sum;
            o_req_id   <= win_idx;
            ptr        <= (win_idx >= LAST_ID) ? '0 : win_idx + ID_LENGTH'(1);
`ifdef ADDER_ARB_OVF_EN
            o_overflow <= ovf_next;
`endif
        end else if (i_ready) begin
            o_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_arbiter_rr.sv
// Directed bench for adder_arbiter_rr (2 requesters, 11-bit); checks
// o_overflow too when ADDER_ARB_OVF_EN is defined.
module tb_adder_arbiter_rr;
    import mips_arb_pkg::*;

    localparam int unsigned LEN = 11;
    localparam int unsigned N   = 2;
    localparam int unsigned IDW = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*LEN-1:0] data_a;
    logic [N*LEN-1:0] data_b;
    logic [N-1:0]     grant;
    logic             valid;
    logic [LEN-1:0]   result;
    logic [IDW-1:0]   req_id;
    logic             ready;
`ifdef ADDER_ARB_OVF_EN
    logic             overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_arbiter_rr #(
        .INPUT_OUTPUT_LENGTH (LEN),
        .NUM_REQ             (N),
        .ID_LENGTH           (IDW)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_req      (req),
        .i_data_A   (data_a),
        .i_data_B   (data_b),
        .o_grant    (grant),
        .o_valid    (valid),
        .o_result   (result),
        .o_req_id   (req_id),
`ifdef ADDER_ARB_OVF_EN
        .o_overflow (overflow),
`endif
        .i_ready    (ready)
    );

    typedef struct {
        logic [1:0]  req;
        logic [10:0] a0, b0, a1, b1;
        logic        ready;
        logic [1:0]  grant;
        logic        valid;
        logic [10:0] res;
        logic        id;
        logic        ovf;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [1:0] rq, input logic [10:0] a0, input logic [10:0] b0,
                                input logic [10:0] a1, input logic [10:0] b1, input logic rdy,
                                input logic [1:0] g, input logic v, input logic [10:0] r,
                                input logic id, input logic ovf);
        vec_t t;
        t.req = rq; t.a0 = a0; t.b0 = b0; t.a1 = a1; t.b1 = b1; t.ready = rdy;
        t.grant = g; t.valid = v; t.res = r; t.id = id; t.ovf = ovf;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rq, input logic [10:0] a0, input logic [10:0] b0,
                         input logic [10:0] a1, input logic [10:0] b1, input logic rdy);
        req    = rq;
        data_a = {a1, a0};
        data_b = {b1, b0};
        ready  = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [10:0] r, input logic id);
        check({tag, ".valid"}, 32'(valid), 32'(v));
        check({tag, ".result"}, 32'(result), 32'(r));
        check({tag, ".id"}, 32'(req_id), 32'(id));
    endtask

    initial begin
        // Stateful sequence from reset: pointer starts at 0.
        vecs[0]  = mk(2'b01, 11'd100, 11'd4,     11'd0,    11'd0,     1'b1, 2'b01, 1'b1, 11'd104,  1'b0, 1'b0);
        vecs[1]  = mk(2'b11, 11'd10,  11'd5,     11'd200,  11'h7FD,   1'b1, 2'b10, 1'b1, 11'd197,  1'b1, 1'b0);
        vecs[2]  = mk(2'b11, 11'd10,  11'd5,     11'd200,  11'h7FD,   1'b1, 2'b01, 1'b1, 11'd15,   1'b0, 1'b0);
        vecs[3]  = mk(2'b11, 11'd10,  11'd5,     11'd200,  11'h7FD,   1'b1, 2'b10, 1'b1, 11'd197,  1'b1, 1'b0);
        vecs[4]  = mk(2'b11, 11'd10,  11'd5,     11'd200,  11'h7FD,   1'b1, 2'b01, 1'b1, 11'd15,   1'b0, 1'b0);
        vecs[5]  = mk(2'b01, 11'd4,   11'h7F8,   11'd0,    11'd0,     1'b1, 2'b01, 1'b1, 11'h7FC,  1'b0, 1'b1);
        vecs[6]  = mk(2'b10, 11'd0,   11'd0,     11'd20,   11'h7F8,   1'b1, 2'b10, 1'b1, 11'd12,   1'b1, 1'b0);
        vecs[7]  = mk(2'b00, 11'd0,   11'd0,     11'd0,    11'd0,     1'b1, 2'b00, 1'b0, 11'd12,   1'b1, 1'b0);
        vecs[8]  = mk(2'b00, 11'd0,   11'd0,     11'd0,    11'd0,     1'b0, 2'b00, 1'b0, 11'd12,   1'b1, 1'b0);
        vecs[9]  = mk(2'b10, 11'd0,   11'd0,     11'd2047, 11'd1,     1'b0, 2'b10, 1'b1, 11'd0,    1'b1, 1'b1);
        vecs[10] = mk(2'b01, 11'd7,   11'd7,     11'd0,    11'd0,     1'b0, 2'b00, 1'b1, 11'd0,    1'b1, 1'b1);
        vecs[11] = mk(2'b01, 11'd7,   11'd7,     11'd0,    11'd0,     1'b0, 2'b00, 1'b1, 11'd0,    1'b1, 1'b1);
        vecs[12] = mk(2'b01, 11'd7,   11'd7,     11'd0,    11'd0,     1'b1, 2'b01, 1'b1, 11'd14,   1'b0, 1'b0);

        rst = 1'b1;
        drive(2'b11, 11'd1, 11'd1, 11'd2, 11'd2, 1'b1);
        #1;
        check("reset.grant", 32'(grant), 32'd0);
        tick;
        check_out("reset", 1'b0, 11'd0, 1'b0);
        tick;
        rst = 1'b0;
        drive(2'b00, 11'd0, 11'd0, 11'd0, 11'd0, 1'b1);
        tick;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].req, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, vecs[i].ready);
            #1;
            check($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].grant));
            tick;
            check_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].res, vecs[i].id);
`ifdef ADDER_ARB_OVF_EN
            check($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vecs[i].ovf));
`endif
        end

        // Backpressure with requester 1 pending; held result is 14 from req 0.
        for (int c = 0; c < 3; c++) begin
            drive(2'b10, 11'd0, 11'd0, 11'd50, 11'd25, 1'b0);
            #1;
            check($sformatf("bp%0d.grant", c), 32'(grant), 32'd0);
            tick;
            check_out($sformatf("bp%0d", c), 1'b1, 11'd14, 1'b0);
        end
        drive(2'b10, 11'd0, 11'd0, 11'd50, 11'd25, 1'b1);
        #1;
        check("bp_release.grant", 32'(grant), 32'b10);
        tick;
        check_out("bp_release", 1'b1, 11'd75, 1'b1);

        // Advance the pointer to 1, then reset while a result is held.
        drive(2'b01, 11'd1, 11'd1, 11'd0, 11'd0, 1'b1);
        #1;
        check("pre_rst.grant", 32'(grant), 32'b01);
        tick;
        check_out("pre_rst", 1'b1, 11'd2, 1'b0);
        drive(2'b11, 11'd1, 11'd1, 11'd3, 11'd3, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst.grant", 32'(grant), 32'd0);
        tick;
        check_out("mid_rst", 1'b0, 11'd0, 1'b0);
        rst = 1'b0;
        drive(2'b11, 11'd1, 11'd1, 11'd3, 11'd3, 1'b1);
        #1;
        check("post_rst.grant", 32'(grant), 32'(1 << REQ_PC));
        tick;
        check_out("post_rst", 1'b1, 11'd2, 1'b0);
        drive(2'b11, 11'd1, 11'd1, 11'd3, 11'd3, 1'b1);
        #1;
        check("post_rst2.grant", 32'(grant), 32'(1 << REQ_BRANCH));
        tick;
        check_out("post_rst2", 1'b1, 11'd6, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
